// File: rtl/rv32_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : rv32_ctrl_pkg                                                |
// | Description : Shared definitions for the RV32I multi-cycle sequencer:      |
// |               state encoding, opcode constants, TYPES bit positions,       |
// |               write-back select codes and FUNCT field sanitising helpers.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rv32_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // TYPES vector bit positions, {R,I,L,S,J,B,U} with R in bit 6
  localparam int T_R = 6;
  localparam int T_I = 5;
  localparam int T_L = 4;
  localparam int T_S = 3;
  localparam int T_J = 2;
  localparam int T_B = 1;
  localparam int T_U = 0;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  // Branches reuse the ALU as a plain adder for PC+imm, so both FUNCT
  // fields are neutralised for them.
  function automatic logic [2:0] sanitise_funct3(input logic [6:0] types,
                                                 input logic [2:0] f3);
    return types[T_B] ? 3'b000 : f3;
  endfunction

  // For I-type only the shift-right immediates (funct3=101) carry a real
  // funct7 (SRLI/SRAI); elsewhere those bits are immediate and must not
  // leak into the ALU operation select.
  function automatic logic [6:0] sanitise_funct7(input logic [6:0] types,
                                                 input logic [2:0] f3,
                                                 input logic [6:0] f7);
    logic [6:0] r;
    r = f7;
    if (types[T_B]) begin
      r = 7'd0;
    end else if (types[T_I] && (f3 != 3'b101)) begin
      r = 7'd0;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_type_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv32_type_decode                                             |
// | Description : Combinational RV32I opcode classifier.                       |
// |               opcode_i  [6:0] : instruction bits [6:0]                     |
// |               types_o   [6:0] : {R,I,L,S,J,B,U}; JALR sets both J and I    |
// |               illegal_o       : opcode is not one of the supported classes |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rv32_type_decode
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [6:0] types_o,
  output logic       illegal_o
);

  always_comb begin
    types_o   = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_OP:     types_o[T_R] = 1'b1;
      OPC_OP_IMM: types_o[T_I] = 1'b1;
      OPC_LOAD:   types_o[T_L] = 1'b1;
      OPC_STORE:  types_o[T_S] = 1'b1;
      OPC_JAL:    types_o[T_J] = 1'b1;
      OPC_JALR: begin
        types_o[T_J] = 1'b1;
        types_o[T_I] = 1'b1;
      end
      OPC_BRANCH: types_o[T_B] = 1'b1;
      OPC_LUI,
      OPC_AUIPC:  types_o[T_U] = 1'b1;
      default:    illegal_o    = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv32_exec_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv32_exec_ctrl                                               |
// | Description : Multi-cycle RV32I sequencer. Owns PC and IR, fetches,        |
// |               classifies the opcode, and steps through execute, data      |
// |               memory access and register write-back, one instruction at   |
// |               a time.                                                      |
// |   clk_i, rst_i              : clock, synchronous active-high reset         |
// |   imem_req/addr/valid/rdata : instruction fetch handshake                  |
// |   dmem_req/we/addr/valid    : data access handshake                        |
// |   alu_out_i, br_taken_i     : datapath results for the current instruction |
// |   pc_o, opcode/funct3/funct7_o, types_o, rs1/rs2/rd_addr_o : decode view   |
// |   rf_we_o, wb_sel_o         : register write-back control                  |
// |   trap_o                    : sticky illegal-opcode / misaligned flag      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rv32_exec_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_valid_i,
  input  logic [31:0]           imem_rdata_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  input  logic                  dmem_valid_i,
  input  logic [DATA_WIDTH-1:0] alu_out_i,
  input  logic                  br_taken_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [6:0]            opcode_o,
  output logic [2:0]            funct3_o,
  output logic [6:0]            funct7_o,
  output logic [6:0]            types_o,
  output logic [4:0]            rs1_addr_o,
  output logic [4:0]            rs2_addr_o,
  output logic [4:0]            rd_addr_o,
  output logic                  rf_we_o,
  output logic [1:0]            wb_sel_o,
  output logic                  trap_o
);

  state_e                state_q,    state_d;
  logic [DATA_WIDTH-1:0] pc_q,       pc_d;
  logic [DATA_WIDTH-1:0] result_q,   result_d;
  logic [DATA_WIDTH-1:0] target_q,   target_d;
  logic [31:0]           ir_q,       ir_d;
  logic [6:0]            types_q,    types_d;
  logic                  illegal_q,  illegal_d;
  logic                  imem_req_q, imem_req_d;
  logic                  dmem_req_q, dmem_req_d;
  logic                  dmem_we_q,  dmem_we_d;
  logic                  rf_we_q,    rf_we_d;
  logic [1:0]            wb_sel_q,   wb_sel_d;
  logic                  trap_q,     trap_d;

  logic [6:0]            w_dec_types;
  logic                  w_dec_illegal;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_br_target;
  logic [DATA_WIDTH-1:0] w_jmp_target;
  logic                  w_fields_vis;

  // Classification happens on the fetched word so TYPES is already
  // registered when DECODE is entered.
  rv32_type_decode u_type_decode (
    .opcode_i  (imem_rdata_i[6:0]),
    .types_o   (w_dec_types),
    .illegal_o (w_dec_illegal)
  );

  assign w_pc_plus4   = pc_q + DATA_WIDTH'(4);
  assign w_br_target  = br_taken_i ? alu_out_i : w_pc_plus4;
  assign w_jmp_target = {alu_out_i[DATA_WIDTH-1:1], 1'b0};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    result_d  = result_q;
    target_d  = target_q;
    ir_d      = ir_q;
    types_d   = types_q;
    illegal_d = illegal_q;
    trap_d    = trap_q;

    case (state_q)
      ST_FETCH: begin
        // A VALID without an outstanding request (e.g. straight after
        // reset) is stale and must not be captured.
        if (imem_req_q && imem_valid_i) begin
          ir_d      = imem_rdata_i;
          types_d   = w_dec_types;
          illegal_d = w_dec_illegal;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = illegal_q ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        result_d = alu_out_i;
        if (types_q[T_L] || types_q[T_S]) begin
          state_d = ST_MEM;
        end else if (types_q[T_B]) begin
          if (w_br_target[1]) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = w_br_target;
            state_d = ST_FETCH;
          end
        end else if (types_q[T_J]) begin
          // Checked before I so JALR takes the jump path.
          target_d = w_jmp_target;
          state_d  = w_jmp_target[1] ? ST_HALT : ST_WB;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_req_q && dmem_valid_i) begin
          if (types_q[T_S]) begin
            pc_d    = w_pc_plus4;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        pc_d    = types_q[T_J] ? target_q : w_pc_plus4;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    if (state_d == ST_HALT) begin
      trap_d = 1'b1;
    end

    // Handshake and write-back strobes are registered from the next state,
    // so they are clean flop outputs, drop on the reset edge, and stay
    // stable for the whole time a state is held.
    imem_req_d = (state_d == ST_FETCH);
    dmem_req_d = (state_d == ST_MEM);
    dmem_we_d  = (state_d == ST_MEM) && types_q[T_S];
    rf_we_d    = (state_d == ST_WB) && (ir_q[11:7] != 5'd0);
    wb_sel_d   = WB_ALU;
    if (state_d == ST_WB) begin
      if (types_q[T_J]) begin
        wb_sel_d = WB_PC4;
      end else if (types_q[T_L]) begin
        wb_sel_d = WB_LOAD;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      result_q   <= '0;
      target_q   <= '0;
      ir_q       <= '0;
      types_q    <= '0;
      illegal_q  <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      wb_sel_q   <= WB_ALU;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      result_q   <= result_d;
      target_q   <= target_d;
      ir_q       <= ir_d;
      types_q    <= types_d;
      illegal_q  <= illegal_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      rf_we_q    <= rf_we_d;
      wb_sel_q   <= wb_sel_d;
      trap_q     <= trap_d;
    end
  end

  // Decoded fields are shown only while an instruction is in flight.
  assign w_fields_vis = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                        (state_q == ST_MEM)    || (state_q == ST_WB);

  assign types_o  = w_fields_vis ? types_q : 7'd0;
  assign opcode_o = w_fields_vis ? ir_q[6:0] : 7'd0;
  assign funct3_o = w_fields_vis ? sanitise_funct3(types_q, ir_q[14:12]) : 3'd0;
  assign funct7_o = w_fields_vis ?
                    sanitise_funct7(types_q, ir_q[14:12], ir_q[31:25]) : 7'd0;

  assign rs1_addr_o  = ir_q[19:15];
  assign rs2_addr_o  = ir_q[24:20];
  assign rd_addr_o   = ir_q[11:7];

  assign imem_req_o  = imem_req_q;
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign dmem_req_o  = dmem_req_q;
  assign dmem_we_o   = dmem_we_q;
  assign dmem_addr_o = result_q;
  assign rf_we_o     = rf_we_q;
  assign wb_sel_o    = wb_sel_q;
  assign trap_o      = trap_q;

endmodule
`default_nettype wire
